// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable wait states,
// lane-shifted byte/half/word stores and sign/zero-extended loads; bad requests are flagged.
module dmem_responder #(
   parameter int AW          = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_vld,
   output logic        req_ready,
   input  logic [3:0]  rden,
   input  logic        rden_SEXT,
   input  logic [3:0]  wren,
   input  logic [31:0] addr,
   input  logic [31:0] wrdata,
   output logic        rsp_vld,
   output logic [31:0] rsp_data,
   output logic        rsp_err
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t state;
   logic [3:0] cnt, l_rd, l_wr, f_rd, f_wr, f_sz, be;
   logic l_sx, f_sx, acc, go, err, misal, unused_hi;
   logic [AW+1:0] l_a, f_a;
   logic [31:0] l_wd, f_wd, wd, sh, ext;
   logic [31:0] mem [2**AW];
   assign unused_hi = ^addr[31:AW+2];
   assign req_ready = state != S_WAIT;
   assign acc = req_vld && req_ready;
   // with no wait states the access edge is the accept edge, so live inputs feed the access
   assign go = (state == S_WAIT) ? cnt == 4'd0 : acc && WAIT_CYCLES == 0;
   always_comb begin
      f_rd = (state == S_WAIT) ? l_rd : rden;
      f_wr = (state == S_WAIT) ? l_wr : wren;
      f_sx = (state == S_WAIT) ? l_sx : rden_SEXT;
      f_a = (state == S_WAIT) ? l_a : addr[AW+1:0];
      f_wd = (state == S_WAIT) ? l_wd : wrdata;
      f_sz = f_rd | f_wr;
      misal = (f_sz == 4'h3 && f_a[0]) || (f_sz == 4'hF && f_a[1:0] != 2'd0);
      err = !(f_rd inside {4'h0, 4'h1, 4'h3, 4'hF}) || !(f_wr inside {4'h0, 4'h1, 4'h3, 4'hF}) ||
            ((f_rd != 4'h0) == (f_wr != 4'h0)) || misal;
      be = f_wr << f_a[1:0];
      wd = f_wd << {f_a[1:0], 3'b000};
      sh = mem[f_a[AW+1:2]] >> {f_a[1:0], 3'b000};
      ext = (f_rd == 4'h1) ? {{24{f_sx & sh[7]}}, sh[7:0]} :
            (f_rd == 4'h3) ? {{16{f_sx & sh[15]}}, sh[15:0]} : sh;
   end
   // array lives in the reset block so an access edge under reset never writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt <= 4'd0;
         rsp_vld <= 1'b0;
         rsp_data <= 32'd0;
         rsp_err <= 1'b0;
         l_rd <= 4'd0;
         l_wr <= 4'd0;
         l_sx <= 1'b0;
         l_a <= '0;
         l_wd <= 32'd0;
      end else begin
         if (acc) begin
            l_rd <= rden;
            l_wr <= wren;
            l_sx <= rden_SEXT;
            l_a <= addr[AW+1:0];
            l_wd <= wrdata;
         end
         cnt <= acc ? 4'(WAIT_CYCLES - 1) : cnt - 4'(state == S_WAIT && cnt != 4'd0);
         state <= acc ? (WAIT_CYCLES > 0 ? S_WAIT : S_RESP) :
                  go ? S_RESP : (state == S_WAIT ? S_WAIT : S_IDLE);
         rsp_vld <= go;
         if (go) begin
            rsp_err <= err;
            rsp_data <= (err || f_rd == 4'h0) ? 32'd0 : ext;
            if (!err)
               for (int i = 0; i < 4; i++)
                  if (be[i]) mem[f_a[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of two responders (0 and 3 wait states)
// against a byte-addressed reference model.
module tb_dmem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n [2], vld [2], ready [2], sx [2], rvld [2], rerr [2];
   logic [3:0] rd [2], wr [2];
   logic [31:0] a [2], wd [2], rdata [2];
   logic [7:0] mb [2][4096];
   int n_assert = 0, n_fail = 0;

   dmem_responder #(.AW(10), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst_n[0]), .req_vld(vld[0]), .req_ready(ready[0]), .rden(rd[0]),
      .rden_SEXT(sx[0]), .wren(wr[0]), .addr(a[0]), .wrdata(wd[0]), .rsp_vld(rvld[0]),
      .rsp_data(rdata[0]), .rsp_err(rerr[0]));
   dmem_responder #(.AW(10), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst_n[1]), .req_vld(vld[1]), .req_ready(ready[1]), .rden(rd[1]),
      .rden_SEXT(sx[1]), .wren(wr[1]), .addr(a[1]), .wrdata(wd[1]), .rsp_vld(rvld[1]),
      .rsp_data(rdata[1]), .rsp_err(rerr[1]));

   function automatic int wc(input int d);
      return d != 0 ? 3 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // byte-addressed model: an access touches nb consecutive bytes starting at the address
   function automatic void model(input int d, input logic [3:0] r, input logic [3:0] w,
                                 input logic s, input logic [31:0] ad, input logic [31:0] wdat,
                                 output logic [31:0] data, output logic e);
      logic [3:0] m;
      logic [31:0] v;
      int nb, base;
      m = r | w;
      nb = (m == 4'h1) ? 1 : (m == 4'h3) ? 2 : 4;
      e = !(r inside {4'h0, 4'h1, 4'h3, 4'hF}) || !(w inside {4'h0, 4'h1, 4'h3, 4'hF}) ||
          (r != 0 && w != 0) || m == 0 || (int'(ad[1:0]) % nb != 0);
      base = int'(ad[11:0]);
      data = 32'd0;
      v = 32'd0;
      if (!e)
         for (int b = 0; b < nb; b++) begin
            if (w != 0) mb[d][base + b] = wdat[8*b +: 8];
            v[8*b +: 8] = mb[d][base + b];
         end
      if (!e && r != 0) begin
         if (nb < 4 && s && v[8*nb-1])
            for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
         data = v;
      end
   endfunction

   task automatic set_req(input int d, input logic [3:0] r, input logic [3:0] w, input logic s,
                          input logic [31:0] ad, input logic [31:0] wdat);
      rd[d] = r;
      wr[d] = w;
      sx[d] = s;
      a[d] = ad;
      wd[d] = wdat;
   endtask

   task automatic do_req(input int d, input logic [3:0] r, input logic [3:0] w, input logic s,
                         input logic [31:0] ad, input logic [31:0] wdat, input string tag,
                         output logic [31:0] got);
      logic [31:0] ed;
      logic ee;
      model(d, r, w, s, ad, wdat, ed, ee);
      @(negedge clk);
      set_req(d, r, w, s, ad, wdat);
      vld[d] = 1'b1;
      chk({tag, " ready"}, 32'(ready[d]), 32'd1);
      @(posedge clk);
      #1 vld[d] = 1'b0;
      repeat (wc(d)) @(posedge clk);
      @(negedge clk);
      chk({tag, " rsp_vld"}, 32'(rvld[d]), 32'd1);
      chk({tag, " rsp_data"}, rdata[d], ed);
      chk({tag, " rsp_err"}, 32'(rerr[d]), 32'(ee));
      got = rdata[d];
   endtask

   initial begin
      logic [31:0] g, ed, ad;
      logic ee;
      logic [3:0] m, r, w;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         vld[d] = 1'b0;
         set_req(d, 4'h0, 4'h0, 1'b0, 32'd0, 32'd0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset ready", 32'(ready[d]), 32'd1);
         chk("reset rsp_vld", 32'(rvld[d]), 32'd0);
         chk("reset rsp_data", rdata[d], 32'd0);
         chk("reset rsp_err", 32'(rerr[d]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      // zero wait states: back-to-back store then load
      model(0, 4'h0, 4'hF, 1'b0, 32'h10, 32'hDEADBEEF, ed, ee);
      model(0, 4'hF, 4'h0, 1'b0, 32'h10, 32'd0, ed, ee);
      @(negedge clk);
      set_req(0, 4'h0, 4'hF, 1'b0, 32'h10, 32'hDEADBEEF);
      vld[0] = 1'b1;
      @(negedge clk);
      chk("b2b sw rsp_vld", 32'(rvld[0]), 32'd1);
      chk("b2b sw rsp_err", 32'(rerr[0]), 32'd0);
      set_req(0, 4'hF, 4'h0, 1'b0, 32'h10, 32'd0);
      @(negedge clk);
      chk("b2b lw rsp_vld", 32'(rvld[0]), 32'd1);
      chk("b2b lw rsp_data", rdata[0], 32'hDEADBEEF);
      chk("b2b lw rsp_err", 32'(rerr[0]), 32'd0);
      vld[0] = 1'b0;
      @(negedge clk);
      chk("idle rsp_vld", 32'(rvld[0]), 32'd0);
      chk("hold rsp_data", rdata[0], 32'hDEADBEEF);
      do_req(0, 4'h0, 4'h1, 1'b0, 32'h13, 32'h00000080, "sb13", g);
      do_req(0, 4'h1, 4'h0, 1'b1, 32'h13, 32'd0, "lb13", g);
      chk("lb13 value", g, 32'hFFFFFF80);
      do_req(0, 4'h1, 4'h0, 1'b0, 32'h13, 32'd0, "lbu13", g);
      chk("lbu13 value", g, 32'h00000080);
      do_req(0, 4'hF, 4'h0, 1'b0, 32'h10, 32'd0, "lw10", g);
      chk("lw10 value", g, 32'h80ADBEEF);
      do_req(0, 4'h3, 4'h0, 1'b1, 32'h12, 32'd0, "lh12", g);
      chk("lh12 value", g, 32'hFFFF80AD);
      do_req(0, 4'h0, 4'hF, 1'b0, 32'h14, 32'h55667788, "sw14", g);
      do_req(0, 4'h3, 4'h0, 1'b1, 32'h11, 32'd0, "lh11 misaligned", g);
      chk("lh11 err", 32'(rerr[0]), 32'd1);
      do_req(0, 4'hF, 4'h0, 1'b0, 32'h12, 32'd0, "lw12 misaligned", g);
      chk("lw12 err", 32'(rerr[0]), 32'd1);
      do_req(0, 4'h0, 4'hF, 1'b0, 32'h16, 32'hFFFFFFFF, "sw16 misaligned", g);
      chk("sw16 err", 32'(rerr[0]), 32'd1);
      do_req(0, 4'h3, 4'h1, 1'b0, 32'h14, 32'h000000EE, "rd+wr malformed", g);
      chk("rd+wr err", 32'(rerr[0]), 32'd1);
      do_req(0, 4'h5, 4'h0, 1'b0, 32'h14, 32'd0, "mask 0101", g);
      chk("mask 0101 err", 32'(rerr[0]), 32'd1);
      do_req(0, 4'h0, 4'h0, 1'b0, 32'h14, 32'd0, "no-op", g);
      chk("no-op err", 32'(rerr[0]), 32'd1);
      do_req(0, 4'hF, 4'h0, 1'b0, 32'h14, 32'd0, "lw14", g);
      chk("lw14 unchanged", g, 32'h55667788);
      // three wait states: second request held on req_vld through the wait
      model(1, 4'h0, 4'hF, 1'b0, 32'h40, 32'hCAFEF00D, ed, ee);
      model(1, 4'hF, 4'h0, 1'b0, 32'h40, 32'd0, ed, ee);
      @(negedge clk);
      set_req(1, 4'h0, 4'hF, 1'b0, 32'h40, 32'hCAFEF00D);
      vld[1] = 1'b1;
      @(posedge clk);
      #1 set_req(1, 4'hF, 4'h0, 1'b0, 32'h40, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk("wait ready", 32'(ready[1]), 32'd0);
         chk("wait rsp_vld", 32'(rvld[1]), 32'd0);
      end
      @(negedge clk);
      chk("t+4 rsp_vld", 32'(rvld[1]), 32'd1);
      chk("t+4 ready", 32'(ready[1]), 32'd1);
      chk("t+4 rsp_err", 32'(rerr[1]), 32'd0);
      @(posedge clk);
      #1 vld[1] = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         @(negedge clk);
         chk("second wait rsp_vld", 32'(rvld[1]), 32'd0);
      end
      @(negedge clk);
      chk("t+8 rsp_vld", 32'(rvld[1]), 32'd1);
      chk("t+8 rsp_data", rdata[1], ed);
      chk("t+8 value", rdata[1], 32'hCAFEF00D);
      // reset while a store waits: store dropped, outputs cleared at once
      do_req(1, 4'h0, 4'hF, 1'b0, 32'h20, 32'hAAAAAAAA, "sw20 old", g);
      do_req(1, 4'hF, 4'h0, 1'b0, 32'h20, 32'd0, "lw20 before", g);
      @(negedge clk);
      set_req(1, 4'h0, 4'hF, 1'b0, 32'h20, 32'h12345678);
      vld[1] = 1'b1;
      @(posedge clk);
      #1 vld[1] = 1'b0;
      @(negedge clk);
      chk("abort wait ready", 32'(ready[1]), 32'd0);
      chk("abort hold rsp_data", rdata[1], 32'hAAAAAAAA);
      rst_n[1] = 1'b0;
      #1;
      chk("abort ready", 32'(ready[1]), 32'd1);
      chk("abort rsp_vld", 32'(rvld[1]), 32'd0);
      chk("abort rsp_data", rdata[1], 32'd0);
      chk("abort rsp_err", 32'(rerr[1]), 32'd0);
      repeat (2) @(negedge clk);
      chk("abort no response", 32'(rvld[1]), 32'd0);
      rst_n[1] = 1'b1;
      do_req(1, 4'hF, 4'h0, 1'b0, 32'h20, 32'd0, "lw20 after", g);
      chk("lw20 old data", g, 32'hAAAAAAAA);
      // random traffic in bytes 0..63 with random ignored high address bits
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++)
            do_req(d, 4'h0, 4'hF, 1'b0, 32'(4*i), $urandom, "fill", g);
         for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2: m = 4'h1;
               3, 4:    m = 4'h3;
               5, 6, 7: m = 4'hF;
               default: m = 4'($urandom);
            endcase
            if ($urandom_range(0, 1) != 0) begin
               r = 4'h0;
               w = m;
            end else begin
               r = m;
               w = 4'h0;
            end
            if ($urandom_range(0, 9) == 0) w = 4'($urandom);
            ad = $urandom & 32'hFFFFF03F;
            if ($urandom_range(0, 3) != 0)
               ad = ad & ~((m == 4'hF) ? 32'd3 : (m == 4'h3) ? 32'd1 : 32'd0);
            do_req(d, r, w, 1'($urandom), ad, $urandom, "random", g);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
